// File: rtl/turn_scheduler.sv
// Two-player chess-clock turn sequencer: alternates turns, issues board commit
// strobes, counts each player's remaining seconds and ends the game on
// surrender or timeout. Every output is a flop loaded from next-state logic.
module turn_scheduler #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIME_W    = 10,
  parameter int INIT_TIME = 600,
  parameter int INC       = 0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic              p1_move_req,
  input  logic              p2_move_req,
  input  logic              p1_surrender,
  input  logic              p2_surrender,
  input  logic              board_done,
  output logic              board_we,
  output logic              board_sel,
  output logic              player1_en,
  output logic              player2_en,
  output logic              clr,
  output logic [7:0]        state,
  output logic [TIME_W-1:0] p1_time,
  output logic [TIME_W-1:0] p2_time,
  output logic [1:0]        winner,
  output logic [1:0]        end_cause
);

  localparam int                PS_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] T_INIT  = TIME_W'(INIT_TIME);
  localparam logic [TIME_W-1:0] T_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_P1_TURN, S_P1_COMMIT, S_P2_TURN, S_P2_COMMIT, S_OVER
  } st_t;

  st_t              st, st_n;
  logic [PS_W-1:0]  presc, presc_n;
  logic [TIME_W-1:0] t1_n, t2_n, cur_time, dec_time, inc_time;
  logic             we_n, sel_n, clr_n;
  logic [1:0]       win_n, cause_n;
  logic [7:0]       state_n;
  logic             in_turn, mover, req, tick;
  logic [31:0]      inc_sum;

  // Display code for a given FSM state; bit0 flags the commit phase.
  function automatic logic [7:0] st_code(st_t s);
    case (s)
      S_P1_TURN:   st_code = 8'h20;
      S_P1_COMMIT: st_code = 8'h21;
      S_P2_TURN:   st_code = 8'h40;
      S_P2_COMMIT: st_code = 8'h41;
      S_OVER:      st_code = 8'h80;
      default:     st_code = 8'h10;
    endcase
  endfunction

  // Shared helpers: who is on move, their clock and request, and the 1 s tick.
  always_comb begin
    in_turn  = (st == S_P1_TURN) || (st == S_P2_TURN);
    mover    = (st == S_P2_TURN) || (st == S_P2_COMMIT);
    cur_time = mover ? p2_time : p1_time;
    req      = mover ? p2_move_req : p1_move_req;
    tick     = in_turn && (presc == PS_LAST);
    dec_time = cur_time - TIME_W'(1);
    inc_sum  = 32'(cur_time) + 32'(INC);
    inc_time = (inc_sum > 32'(T_MAX)) ? T_MAX : TIME_W'(inc_sum);
  end

  // Next-state and next-output logic; priority surrender > timeout > move.
  always_comb begin
    st_n    = st;
    presc_n = presc;
    t1_n    = p1_time;
    t2_n    = p2_time;
    we_n    = 1'b0;
    sel_n   = board_sel;
    clr_n   = 1'b0;
    win_n   = winner;
    cause_n = end_cause;
    case (st)
      S_IDLE, S_OVER: begin
        if (start) begin
          st_n    = S_P1_TURN;
          clr_n   = 1'b1;
          t1_n    = T_INIT;
          t2_n    = T_INIT;
          win_n   = 2'b00;
          cause_n = 2'b00;
          presc_n = '0;
        end
      end
      default: begin
        if (p1_surrender || p2_surrender) begin
          // Resigning player loses; both at once is a draw (11).
          st_n    = S_OVER;
          win_n   = {p1_surrender, p2_surrender};
          cause_n = 2'b01;
        end else if (in_turn) begin
          presc_n = tick ? '0 : presc + PS_W'(1);
          if (tick && (cur_time <= TIME_W'(1))) begin
            st_n    = S_OVER;
            win_n   = mover ? 2'b01 : 2'b10;
            cause_n = 2'b10;
            if (mover) t2_n = '0;
            else       t1_n = '0;
          end else begin
            if (tick) begin
              if (mover) t2_n = dec_time;
              else       t1_n = dec_time;
            end
            if (req) begin
              st_n  = mover ? S_P2_COMMIT : S_P1_COMMIT;
              we_n  = 1'b1;
              sel_n = mover;
            end
          end
        end else if (board_done) begin
          // Commit finished: credit increment, hand the turn over.
          presc_n = '0;
          st_n    = mover ? S_P1_TURN : S_P2_TURN;
          if (mover) t2_n = inc_time;
          else       t1_n = inc_time;
        end
      end
    endcase
    state_n = st_code(st_n);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      st         <= S_IDLE;
      presc      <= '0;
      p1_time    <= T_INIT;
      p2_time    <= T_INIT;
      board_we   <= 1'b0;
      board_sel  <= 1'b0;
      player1_en <= 1'b0;
      player2_en <= 1'b0;
      clr        <= 1'b0;
      state      <= 8'h10;
      winner     <= 2'b00;
      end_cause  <= 2'b00;
    end else begin
      st         <= st_n;
      presc      <= presc_n;
      p1_time    <= t1_n;
      p2_time    <= t2_n;
      board_we   <= we_n;
      board_sel  <= sel_n;
      player1_en <= (st_n == S_P1_TURN);
      player2_en <= (st_n == S_P2_TURN);
      clr        <= clr_n;
      state      <= state_n;
      winner     <= win_n;
      end_cause  <= cause_n;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Scoreboard bench for turn_scheduler: each stimulus cycle queues the values
// expected after the next edge; they are popped and compared once it passes.
module tb_turn_scheduler;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0, p1_move_req = 1'b0, p2_move_req = 1'b0;
  logic          p1_surrender = 1'b0, p2_surrender = 1'b0, board_done = 1'b0;
  logic          board_we, board_sel, player1_en, player2_en, clr;
  logic [7:0]    state;
  logic [TW-1:0] p1_time, p2_time;
  logic [1:0]    winner, end_cause;

  turn_scheduler #(.TICK_DIV(4), .TIME_W(TW), .INIT_TIME(3), .INC(1)) dut (
    .clk(clk), .nRST(nRST), .start(start),
    .p1_move_req(p1_move_req), .p2_move_req(p2_move_req),
    .p1_surrender(p1_surrender), .p2_surrender(p2_surrender),
    .board_done(board_done), .board_we(board_we), .board_sel(board_sel),
    .player1_en(player1_en), .player2_en(player2_en), .clr(clr),
    .state(state), .p1_time(p1_time), .p2_time(p2_time),
    .winner(winner), .end_cause(end_cause)
  );

  always #5 clk = ~clk;

  localparam int SG_STATE = 0, SG_P1T = 1, SG_P2T = 2, SG_WIN = 3, SG_CAUSE = 4,
                 SG_P1EN = 5, SG_P2EN = 6, SG_WE = 7, SG_SEL = 8, SG_CLR = 9;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic int obs(input int s);
    case (s)
      SG_STATE: obs = int'(state);
      SG_P1T:   obs = int'(p1_time);
      SG_P2T:   obs = int'(p2_time);
      SG_WIN:   obs = int'(winner);
      SG_CAUSE: obs = int'(end_cause);
      SG_P1EN:  obs = int'(player1_en);
      SG_P2EN:  obs = int'(player2_en);
      SG_WE:    obs = int'(board_we);
      SG_SEL:   obs = int'(board_sel);
      default:  obs = int'(clr);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  // Advance one clock and compare everything queued for this edge.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
  endtask

  // Watchdog so a broken DUT can never stall the run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then start
    expect_v("rst_state", SG_STATE, 8'h10); expect_v("rst_p1t", SG_P1T, 3);
    expect_v("rst_p2t", SG_P2T, 3);         expect_v("rst_win", SG_WIN, 0);
    expect_v("rst_cause", SG_CAUSE, 0);     expect_v("rst_we", SG_WE, 0);
    expect_v("rst_p1en", SG_P1EN, 0);       expect_v("rst_clr", SG_CLR, 0);
    cyc();
    nRST = 1'b1;
    start = 1'b1;
    expect_v("st_state", SG_STATE, 8'h20);  expect_v("st_clr", SG_CLR, 1);
    expect_v("st_p1en", SG_P1EN, 1);        expect_v("st_p2en", SG_P2EN, 0);
    expect_v("st_p1t", SG_P1T, 3);          expect_v("st_p2t", SG_P2T, 3);
    cyc();
    start = 1'b0;

    // 2: idle play, p1 clock runs out
    for (int v = 2; v >= 0; v--) begin
      repeat (3) begin
        expect_v("to_hold", SG_P1T, v + 1); expect_v("to_run", SG_STATE, 8'h20);
        expect_v("to_clr", SG_CLR, 0);
        cyc();
      end
      expect_v("to_tick", SG_P1T, v);
      if (v == 0) begin
        expect_v("to_state", SG_STATE, 8'h80); expect_v("to_win", SG_WIN, 2);
        expect_v("to_cause", SG_CAUSE, 2);     expect_v("to_p1en", SG_P1EN, 0);
        expect_v("to_p2t", SG_P2T, 3);
      end
      cyc();
    end
    p1_move_req = 1'b1;
    expect_v("over_sticky", SG_STATE, 8'h80); expect_v("over_p1t", SG_P1T, 0);
    cyc();
    p1_move_req = 1'b0;

    // 3: p1 commit with delayed board_done
    start = 1'b1;
    expect_v("rs_state", SG_STATE, 8'h20); expect_v("rs_p1t", SG_P1T, 3);
    expect_v("rs_win", SG_WIN, 0);         expect_v("rs_cause", SG_CAUSE, 0);
    expect_v("rs_clr", SG_CLR, 1);
    cyc();
    start = 1'b0;
    p1_move_req = 1'b1;
    expect_v("c1_state", SG_STATE, 8'h21); expect_v("c1_we", SG_WE, 1);
    expect_v("c1_sel", SG_SEL, 0);         expect_v("c1_p1en", SG_P1EN, 0);
    cyc();
    p1_move_req = 1'b0;
    expect_v("c1_we_once", SG_WE, 0); expect_v("c1_hold", SG_STATE, 8'h21);
    cyc();
    expect_v("c1_hold2", SG_STATE, 8'h21); expect_v("c1_frz", SG_P1T, 3);
    cyc();
    board_done = 1'b1;
    expect_v("d1_state", SG_STATE, 8'h40); expect_v("d1_p1t", SG_P1T, 4);
    expect_v("d1_p2en", SG_P2EN, 1);       expect_v("d1_p1en", SG_P1EN, 0);
    cyc();
    board_done = 1'b0;
    p1_move_req = 1'b1;
    expect_v("p2_ign_p1", SG_STATE, 8'h40); expect_v("p2_we", SG_WE, 0);
    cyc();
    p1_move_req = 1'b0;
    board_done = 1'b1;
    expect_v("stray_done", SG_STATE, 8'h40); expect_v("stray_p1t", SG_P1T, 4);
    cyc();
    board_done = 1'b0;

    // 4: simultaneous surrender -> draw
    p1_surrender = 1'b1; p2_surrender = 1'b1;
    expect_v("dr_state", SG_STATE, 8'h80); expect_v("dr_win", SG_WIN, 3);
    expect_v("dr_cause", SG_CAUSE, 1);     expect_v("dr_p2en", SG_P2EN, 0);
    cyc();
    p1_surrender = 1'b0; p2_surrender = 1'b0;

    // 5: p2 resigns while p1 commits; late board_done ignored
    start = 1'b1;
    expect_v("g5_state", SG_STATE, 8'h20); expect_v("g5_win", SG_WIN, 0);
    cyc();
    start = 1'b0;
    p1_move_req = 1'b1;
    expect_v("g5_commit", SG_STATE, 8'h21); expect_v("g5_we", SG_WE, 1);
    cyc();
    p1_move_req = 1'b0;
    p2_surrender = 1'b1;
    expect_v("sc_state", SG_STATE, 8'h80); expect_v("sc_win", SG_WIN, 1);
    expect_v("sc_cause", SG_CAUSE, 1);     expect_v("sc_we", SG_WE, 0);
    cyc();
    p2_surrender = 1'b0;
    board_done = 1'b1;
    expect_v("late_state", SG_STATE, 8'h80); expect_v("late_p1t", SG_P1T, 3);
    expect_v("late_win", SG_WIN, 1);
    cyc();
    board_done = 1'b0;

    // 6: p2 commit path, then reset in P2_TURN and restart
    start = 1'b1;
    expect_v("g6_state", SG_STATE, 8'h20);
    cyc();
    start = 1'b0;
    p1_move_req = 1'b1;
    expect_v("g6_c1", SG_STATE, 8'h21);
    cyc();
    p1_move_req = 1'b0;
    board_done = 1'b1;
    expect_v("g6_p2turn", SG_STATE, 8'h40);
    cyc();
    board_done = 1'b0;
    p2_move_req = 1'b1;
    expect_v("c2_state", SG_STATE, 8'h41); expect_v("c2_we", SG_WE, 1);
    expect_v("c2_sel", SG_SEL, 1);         expect_v("c2_p2en", SG_P2EN, 0);
    cyc();
    p2_move_req = 1'b0;
    board_done = 1'b1;
    expect_v("d2_state", SG_STATE, 8'h20); expect_v("d2_p2t", SG_P2T, 4);
    expect_v("d2_p1en", SG_P1EN, 1);
    cyc();
    board_done = 1'b0;
    p1_move_req = 1'b1;
    expect_v("g6_c1b", SG_STATE, 8'h21);
    cyc();
    p1_move_req = 1'b0;
    board_done = 1'b1;
    expect_v("g6_back", SG_STATE, 8'h40); expect_v("g6_p1t", SG_P1T, 5);
    cyc();
    board_done = 1'b0;
    nRST = 1'b0;
    expect_v("mr_state", SG_STATE, 8'h10); expect_v("mr_p1t", SG_P1T, 3);
    expect_v("mr_p2t", SG_P2T, 3);         expect_v("mr_p2en", SG_P2EN, 0);
    expect_v("mr_p1en", SG_P1EN, 0);       expect_v("mr_we", SG_WE, 0);
    expect_v("mr_sel", SG_SEL, 0);         expect_v("mr_clr", SG_CLR, 0);
    expect_v("mr_win", SG_WIN, 0);         expect_v("mr_cause", SG_CAUSE, 0);
    cyc();
    nRST = 1'b1;
    start = 1'b1;
    expect_v("rr_state", SG_STATE, 8'h20); expect_v("rr_clr", SG_CLR, 1);
    expect_v("rr_p1en", SG_P1EN, 1);
    cyc();
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
